// File: rtl/power_seq_pkg.sv
// Shared types for the iterative masked CLM power sequencer: share layout,
// reduction randomness, reduction matrix and the sequencer state encoding.
package power_seq_pkg;

    localparam int d      = 1;
    localparam int SHARES = d + 1;
    localparam int N      = 8;

    typedef logic [SHARES-1:0][N-1:0] state_t;
    typedef logic [d-1:0][N-1:0]      red_poly_t;
    // Row j holds x^(N+j) reduced modulo the field polynomial.
    typedef logic [N-2:0][N-1:0]      nm_matrix_t;

    typedef enum logic [1:0] {PS_IDLE, PS_SQR, PS_DONE} pow_seq_state_t;

    function automatic int clamp_sq(input int n, input int max_sq);
        return (n > max_sq) ? max_sq : n;
    endfunction

endpackage

// File: rtl/power_seq_square.sv
// Combinational masked CLM squarer: per-share bit spread, matrix reduction of
// the high half, then a refresh with r that leaves the unmasked value intact.
module square
    import power_seq_pkg::*;
#(
    parameter int d = power_seq_pkg::d
) (
    input  state_t     x,
    input  red_poly_t  r,
    input  nm_matrix_t b,
    output state_t     y
);

    logic [SHARES-1:0][2*N-2:0] spread;

    always_comb begin
        spread = '0;
        for (int unsigned s = 0; s < SHARES; s++) begin
            for (int unsigned i = 0; i < N; i++) begin
                spread[s][2*i] = x[s][i];
            end
        end
    end

    always_comb begin
        y = '0;
        for (int unsigned s = 0; s < SHARES; s++) begin
            y[s] = spread[s][N-1:0];
            for (int unsigned j = 0; j < N - 1; j++) begin
                if (spread[s][N+j]) y[s] = y[s] ^ b[j];
            end
        end
        // Each r word masks one share and the last share, so it cancels on unmasking.
        for (int unsigned i = 0; i < d; i++) begin
            y[i]        = y[i] ^ r[i];
            y[SHARES-1] = y[SHARES-1] ^ r[i];
        end
    end

endmodule

// File: rtl/power_seq.sv
// Iterative x^(2^n) over one reused squarer, with valid/ready on job, result and r.
// CLM_FRESH_RAND_EN: defined => fresh r per squaring; undefined => one r per job held in r_q.
module power_seq
    import power_seq_pkg::*;
#(
    parameter int d      = power_seq_pkg::d,
    parameter int MAX_SQ = 4,
    parameter int SQ_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  state_t          in_data,
    input  logic [SQ_W-1:0] n_sq,
    input  nm_matrix_t      B_ext,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    input  red_poly_t       rnd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output state_t          out_data,
    output logic            busy
);

    pow_seq_state_t  state_q, state_d;
    state_t          acc_q, acc_d, sq_y;
    logic [SQ_W-1:0] cnt_q, cnt_d, n_clamped;
    red_poly_t       r_sel;
    logic            step_ok;
    logic            r_req;

    assign n_clamped = SQ_W'(clamp_sq(32'(n_sq), MAX_SQ));

`ifdef CLM_FRESH_RAND_EN
    assign r_sel   = rnd_data;
    assign step_ok = rnd_valid;
    assign r_req   = 1'b1;
`else
    red_poly_t r_q;
    logic      r_have_q;

    // First SQR cycle uses rnd_data directly while capturing it for later steps.
    assign r_sel   = r_have_q ? r_q : rnd_data;
    assign step_ok = r_have_q | rnd_valid;
    assign r_req   = ~r_have_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_have_q <= 1'b0;
        end else if (state_q == PS_IDLE) begin
            r_have_q <= 1'b0;
        end else if (state_q == PS_SQR && !r_have_q && rnd_valid) begin
            r_q      <= rnd_data;
            r_have_q <= 1'b1;
        end
    end
`endif

    square #(.d(d)) u_squarer (
        .x (acc_q),
        .r (r_sel),
        .b (B_ext),
        .y (sq_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rnd_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            PS_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = n_clamped;
                    state_d = (n_clamped == '0) ? PS_DONE : PS_SQR;
                end
            end
            PS_SQR: begin
                busy      = 1'b1;
                rnd_ready = r_req;
                if (step_ok) begin
                    acc_d = sq_y;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SQ_W'(1)) state_d = PS_DONE;
                end
            end
            PS_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = PS_IDLE;
            end
            default: state_d = PS_IDLE;
        endcase
    end

    assign out_data = acc_q;

endmodule
